rand_arbiter: RTL and testbench
===============================

RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter DEFAULT_SEED, 15'h4A5D, seed loaded into the LFSR after reset; SHALL be nonzero.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  level request per requester, bit i = requester i.
REQ-005 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-006 rand_valid  output  1  registered one-cycle pulse; rand_data valid for the granted requester.
REQ-007 rand_data  output  8  registered random byte.
REQ-008 reseed_req  input  1  single-cycle pulse requesting an LFSR reload from seed_in.
REQ-009 seed_in  input  15  new seed, sampled in the cycle reseed_req=1.
REQ-010 lfsr_rst  output  1  registered, drives the LFSR reset/load input.
REQ-011 lfsr_seed  output  15  registered, drives the LFSR seed input.
REQ-012 lfsr_enable  output  1  registered, drives the LFSR block enable.
REQ-013 lfsr_rand  input  8  LFSR output byte; updates one edge after an enabled cycle.

Function
REQ-014 FSM states SHALL be IDLE, SEED, STEP, LOAD, DELIVER.
REQ-015 SEED: lfsr_rst=1, lfsr_seed=held seed for one cycle; next state IDLE.
REQ-016 IDLE: pending reseed SHALL go to SEED; otherwise any req bit set SHALL go to STEP; otherwise stay in IDLE.
REQ-017 IDLE->STEP: gnt SHALL be set to the round-robin winner, searching from (last_grant+1) mod 4 upward; last_grant SHALL update to the winner.
REQ-018 STEP: lfsr_enable=1 for exactly one cycle; next state LOAD.
REQ-019 LOAD: rand_data SHALL capture lfsr_rand; next state DELIVER.
REQ-020 DELIVER: rand_valid=1 for one cycle with gnt unchanged; on exit, gnt SHALL clear to 0 and state SHALL return to IDLE.
REQ-021 Latency: req sampled in IDLE at cycle t SHALL produce rand_valid at cycle t+3; minimum spacing between grants is 4 cycles.
REQ-022 gnt SHALL stay stable from STEP through DELIVER; a req drop after grant SHALL NOT abort the transaction.
REQ-023 A reseed_req outside IDLE SHALL be latched with its seed_in, with the newest pulse winning, and serviced at the next IDLE, before any request.
REQ-024 A reseed_req and a req in the same IDLE cycle: SEED SHALL run first, then the request.
REQ-025 lfsr_enable and lfsr_rst SHALL never be 1 in the same cycle.
REQ-026 rand_data SHALL hold its last value between deliveries.

Reset
REQ-027 On rst: state=SEED, held seed=DEFAULT_SEED, last_grant=3, gnt=0, rand_valid=0, rand_data=0, lfsr_enable=0, lfsr_rst=0, lfsr_seed=DEFAULT_SEED, reseed pending cleared.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; no rand_valid SHALL follow.
REQ-029 The first cycle after rst deassert SHALL drive lfsr_rst=1 with DEFAULT_SEED.

Configuration
REQ-030 Macro SEED_ZERO_GUARD_EN defined: a seed_in of 15'h0000 SHALL be replaced by DEFAULT_SEED when latched.
REQ-031 SEED_ZERO_GUARD_EN undefined: seed_in SHALL be passed unmodified, including zero.

Verification
REQ-032 rst, then idle -> lfsr_rst=1 and lfsr_seed=15'h4A5D in the first cycle after reset; gnt=0 and rand_valid=0 thereafter.
REQ-033 req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001; rand_valid every 4 cycles; rand_data equals lfsr_rand sampled in LOAD.
REQ-034 req=4'b0100 at cycle t in IDLE -> gnt=0100 at t+1 through t+3; lfsr_enable at t+1 only; rand_valid at t+3.
REQ-035 reseed_req with seed_in=15'h1234 during STEP -> transaction completes; next IDLE enters SEED with lfsr_seed=15'h1234 before the next grant.
REQ-036 seed_in=15'h0000 reseed -> lfsr_seed=15'h4A5D with SEED_ZERO_GUARD_EN defined; 15'h0000 without it.
REQ-037 rst asserted in LOAD -> no rand_valid; gnt=0 the next cycle; SEED follows.

Source files
------------

// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin arbiter that hands out one random byte per grant.
// Each grant walks IDLE -> STEP -> LOAD -> DELIVER. STEP advances an external
// LFSR for one cycle. LOAD captures the LFSR byte. DELIVER presents it with
// rand_valid.
// Reseed requests are remembered until the next IDLE and always win over
// pending grants there.
// Optional build macro: SEED_ZERO_GUARD_EN. When it is defined, a zero
// seed_in is replaced by DEFAULT_SEED at the moment it is latched.
module rand_arbiter #(
    parameter logic [14:0] DEFAULT_SEED = 15'h4A5D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    output logic [3:0]  gnt,
    output logic        rand_valid,
    output logic [7:0]  rand_data,
    input  logic        reseed_req,
    input  logic [14:0] seed_in,
    output logic        lfsr_rst,
    output logic [14:0] lfsr_seed,
    output logic        lfsr_enable,
    input  logic [7:0]  lfsr_rand
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        STEP    = 3'd2,
        LOAD    = 3'd3,
        DELIVER = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  last_grant_r;
    logic [1:0]  win_idx_s;
    logic [14:0] seed_hold_r;
    logic        reseed_pend_r;
    logic [14:0] load_seed_s;
    logic [3:0]  gnt_r;
    logic        rand_valid_r;
    logic [7:0]  rand_data_r;
    logic        lfsr_rst_r;
    logic [14:0] lfsr_seed_r;
    logic        lfsr_enable_r;

    // Optional zero-seed substitution applied when a seed is latched.
    function automatic logic [14:0] guard_seed(input logic [14:0] seed);
`ifdef SEED_ZERO_GUARD_EN
        guard_seed = (seed == 15'h0000) ? DEFAULT_SEED : seed;
`else
        guard_seed = seed;
`endif
    endfunction

    // Round-robin winner: first requester found scanning upward from last_grant+1.
    always_comb begin : rr_pick
        logic [1:0] cand_v;
        logic       found_v;
        win_idx_s = last_grant_r;
        cand_v    = 2'd0;
        found_v   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand_v = last_grant_r + k[1:0];
            if (!found_v && req[cand_v]) begin
                win_idx_s = cand_v;
                found_v   = 1'b1;
            end else begin
                found_v   = found_v;
            end
        end
    end

    // Seed used on entry to SEED from IDLE: a same-cycle pulse bypasses the hold register.
    always_comb begin
        load_seed_s = seed_hold_r;
        if (reseed_req) begin
            load_seed_s = guard_seed(seed_in);
        end else begin
            load_seed_s = seed_hold_r;
        end
    end

    // Next-state logic. The post-reset SEED visit spends one cycle before the load pulse.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (reseed_req || reseed_pend_r) begin
                    state_next_s = SEED;
                end else if (req != 4'b0000) begin
                    state_next_s = STEP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEED: begin
                if (lfsr_rst_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEED;
                end
            end
            STEP:    state_next_s = LOAD;
            LOAD:    state_next_s = DELIVER;
            DELIVER: state_next_s = IDLE;
            default: state_next_s = SEED;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SEED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Reseed capture: newest seed always held; a request outside IDLE waits as pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_hold_r   <= DEFAULT_SEED;
            reseed_pend_r <= 1'b0;
        end else begin
            if (reseed_req) begin
                seed_hold_r <= guard_seed(seed_in);
            end else begin
                seed_hold_r <= seed_hold_r;
            end
            if (state_r == IDLE) begin
                reseed_pend_r <= 1'b0;
            end else begin
                reseed_pend_r <= reseed_pend_r | reseed_req;
            end
        end
    end

    // LFSR control: reset/load pulse while in SEED, enable pulse while in STEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_rst_r    <= 1'b0;
            lfsr_seed_r   <= DEFAULT_SEED;
            lfsr_enable_r <= 1'b0;
        end else begin
            lfsr_rst_r    <= (state_next_s == SEED);
            lfsr_enable_r <= (state_next_s == STEP);
            if (state_r == IDLE && state_next_s == SEED) begin
                lfsr_seed_r <= load_seed_s;
            end else begin
                lfsr_seed_r <= lfsr_seed_r;
            end
        end
    end

    // Grant: set on IDLE->STEP, held through DELIVER, cleared on leaving DELIVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r        <= 4'b0000;
            last_grant_r <= 2'd3;
        end else begin
            if (state_r == IDLE && state_next_s == STEP) begin
                gnt_r        <= 4'b0001 << win_idx_s;
                last_grant_r <= win_idx_s;
            end else if (state_r == DELIVER) begin
                gnt_r        <= 4'b0000;
                last_grant_r <= last_grant_r;
            end else begin
                gnt_r        <= gnt_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Random byte: captured at the end of LOAD and held; valid pulses during DELIVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            rand_data_r  <= 8'h00;
            rand_valid_r <= 1'b0;
        end else begin
            rand_valid_r <= (state_r == LOAD);
            if (state_r == LOAD) begin
                rand_data_r <= lfsr_rand;
            end else begin
                rand_data_r <= rand_data_r;
            end
        end
    end

    assign gnt         = gnt_r;
    assign rand_valid  = rand_valid_r;
    assign rand_data   = rand_data_r;
    assign lfsr_rst    = lfsr_rst_r;
    assign lfsr_seed   = lfsr_seed_r;
    assign lfsr_enable = lfsr_enable_r;

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter. A transaction-level timeline model schedules the
// expected outputs of future cycles into a small ring. A negedge process
// compares every output against that ring. Directed steps pin literal values.
module tb_rand_arbiter;

    localparam logic [14:0] DEF_SEED = 15'h4A5D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  gnt;
    logic        rand_valid;
    logic [7:0]  rand_data;
    logic        reseed_req = 1'b0;
    logic [14:0] seed_in = 15'h0000;
    logic        lfsr_rst;
    logic [14:0] lfsr_seed;
    logic        lfsr_enable;
    logic [7:0]  lfsr_rand = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    rand_arbiter #(.DEFAULT_SEED(DEF_SEED)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .rand_valid(rand_valid), .rand_data(rand_data),
        .reseed_req(reseed_req), .seed_in(seed_in),
        .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed),
        .lfsr_enable(lfsr_enable), .lfsr_rand(lfsr_rand)
    );

    always #5 clk = ~clk;

    // Simple stand-in for the LFSR: loads from the seed, steps when enabled.
    always @(posedge clk) begin
        if (lfsr_rst) lfsr_rand <= lfsr_seed[7:0] ^ 8'hA5;
        else if (lfsr_enable) lfsr_rand <= lfsr_rand * 8'd5 + 8'd1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] m_guard(input logic [14:0] s);
`ifdef SEED_ZERO_GUARD_EN
        return (s == 15'h0000) ? DEF_SEED : s;
`else
        return s;
`endif
    endfunction

    // ---------------- timeline model ----------------
    logic [3:0]  r_gnt [16];
    bit          r_en  [16];
    bit          r_rst [16];
    bit          r_val [16];
    bit          m_started = 0;
    bit          m_post_rst = 0;
    bit          m_pend = 0;
    bit          m_cap_pend = 0;
    int          m_cyc = 0;
    int          m_idle_from = 0;
    int          m_cap_at = 0;
    int          m_last = 3;
    logic [14:0] m_hold = DEF_SEED;
    logic [14:0] m_seed = DEF_SEED;
    logic [7:0]  m_data = 8'h00;
    logic [3:0]  e_gnt = 4'b0000;
    bit          e_en = 0, e_rst = 0, e_val = 0;

    always @(posedge clk) begin
        bit idle;
        int w;
        m_cyc = m_cyc + 1;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_gnt[i] = 4'b0000; r_en[i] = 0; r_rst[i] = 0; r_val[i] = 0;
            end
            m_started = 1; m_post_rst = 1; m_pend = 0; m_cap_pend = 0;
            m_last = 3; m_hold = DEF_SEED; m_seed = DEF_SEED; m_data = 8'h00;
        end else if (m_started) begin
            if (m_cap_pend && m_cap_at == m_cyc) begin
                m_data = lfsr_rand;
                m_cap_pend = 0;
            end
            idle = !m_post_rst && ((m_cyc - 1) >= m_idle_from);
            if (m_post_rst) begin
                r_rst[m_cyc % 16] = 1;
                m_idle_from = m_cyc + 1;
                m_post_rst = 0;
            end
            if (idle) begin
                if (reseed_req || m_pend) begin
                    m_seed = reseed_req ? m_guard(seed_in) : m_hold;
                    r_rst[m_cyc % 16] = 1;
                    m_idle_from = m_cyc + 1;
                    m_pend = 0;
                end else if (req != 4'b0000) begin
                    w = -1;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
                    m_last = w;
                    for (int d = 0; d < 3; d++) r_gnt[(m_cyc + d) % 16] = 4'b0001 << w;
                    r_en[m_cyc % 16] = 1;
                    r_val[(m_cyc + 2) % 16] = 1;
                    m_cap_at = m_cyc + 2;
                    m_cap_pend = 1;
                    m_idle_from = m_cyc + 3;
                end
            end else if (reseed_req) begin
                m_pend = 1;
            end
            if (reseed_req) m_hold = m_guard(seed_in);
        end
        e_gnt = r_gnt[m_cyc % 16]; e_en = r_en[m_cyc % 16];
        e_rst = r_rst[m_cyc % 16]; e_val = r_val[m_cyc % 16];
        r_gnt[m_cyc % 16] = 4'b0000; r_en[m_cyc % 16] = 0;
        r_rst[m_cyc % 16] = 0; r_val[m_cyc % 16] = 0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("m_gnt", {12'h000, gnt}, {12'h000, e_gnt});
            chk("m_rand_valid", {15'h0000, rand_valid}, {15'h0000, e_val});
            chk("m_lfsr_enable", {15'h0000, lfsr_enable}, {15'h0000, e_en});
            chk("m_lfsr_rst", {15'h0000, lfsr_rst}, {15'h0000, e_rst});
            chk("m_lfsr_seed", {1'b0, lfsr_seed}, {1'b0, m_seed});
            chk("m_rand_data", {8'h00, rand_data}, {8'h00, m_data});
            chk("m_no_overlap", {15'h0000, lfsr_rst & lfsr_enable}, 16'h0000);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] exp_seq [5];
    logic [7:0] lr;
    logic [14:0] zero_exp;

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`ifdef SEED_ZERO_GUARD_EN
        zero_exp = 15'h4A5D;
`else
        zero_exp = 15'h0000;
`endif
        // Reset and first seed pulse.
        repeat (3) cyc();
        chk("rst_gnt", {12'h000, gnt}, 16'h0000);
        chk("rst_valid", {15'h0000, rand_valid}, 16'h0000);
        chk("rst_lfsr_rst", {15'h0000, lfsr_rst}, 16'h0000);
        chk("rst_data", {8'h00, rand_data}, 16'h0000);
        rst = 1'b0;
        cyc();
        chk("seed0_lfsr_rst", {15'h0000, lfsr_rst}, 16'h0001);
        chk("seed0_lfsr_seed", {1'b0, lfsr_seed}, 16'h4A5D);
        cyc();
        chk("seed0_done", {15'h0000, lfsr_rst}, 16'h0000);
        repeat (2) begin
            cyc();
            chk("idle_gnt", {12'h000, gnt}, 16'h0000);
            chk("idle_valid", {15'h0000, rand_valid}, 16'h0000);
        end

        // All requesters held: rotation 0,1,2,3,0.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_gnt", {12'h000, gnt}, {12'h000, exp_seq[i]});
            chk("rr_en", {15'h0000, lfsr_enable}, 16'h0001);
            cyc();
            lr = lfsr_rand;
            cyc();
            chk("rr_valid", {15'h0000, rand_valid}, 16'h0001);
            chk("rr_gnt_hold", {12'h000, gnt}, {12'h000, exp_seq[i]});
            chk("rr_data", {8'h00, rand_data}, {8'h00, lr});
            cyc();
            chk("rr_gnt_clr", {12'h000, gnt}, 16'h0000);
        end
        req = 4'b0000;

        // Single requester, request dropped right after grant.
        req = 4'b0100;
        cyc();
        chk("one_gnt1", {12'h000, gnt}, 16'h0004);
        chk("one_en1", {15'h0000, lfsr_enable}, 16'h0001);
        req = 4'b0000;
        cyc();
        chk("one_gnt2", {12'h000, gnt}, 16'h0004);
        chk("one_en2", {15'h0000, lfsr_enable}, 16'h0000);
        lr = lfsr_rand;
        cyc();
        chk("one_gnt3", {12'h000, gnt}, 16'h0004);
        chk("one_valid", {15'h0000, rand_valid}, 16'h0001);
        chk("one_data", {8'h00, rand_data}, {8'h00, lr});
        cyc();
        chk("one_gnt4", {12'h000, gnt}, 16'h0000);

        // Reseed during STEP is deferred until the next IDLE.
        req = 4'b0010;
        cyc();
        chk("rs_gnt", {12'h000, gnt}, 16'h0002);
        reseed_req = 1'b1; seed_in = 15'h1234;
        cyc();
        reseed_req = 1'b0;
        chk("rs_gnt_hold", {12'h000, gnt}, 16'h0002);
        cyc();
        chk("rs_valid", {15'h0000, rand_valid}, 16'h0001);
        cyc();
        chk("rs_idle", {12'h000, gnt}, 16'h0000);
        cyc();
        chk("rs_lfsr_rst", {15'h0000, lfsr_rst}, 16'h0001);
        chk("rs_lfsr_seed", {1'b0, lfsr_seed}, 16'h1234);
        chk("rs_gnt_seed", {12'h000, gnt}, 16'h0000);
        cyc();
        chk("rs_gnt_after", {12'h000, gnt}, 16'h0000);
        cyc();
        chk("rs_next_gnt", {12'h000, gnt}, 16'h0002);
        req = 4'b0000;
        repeat (3) cyc();

        // Zero seed and request in the same IDLE cycle: SEED first.
        reseed_req = 1'b1; seed_in = 15'h0000; req = 4'b1000;
        cyc();
        reseed_req = 1'b0;
        chk("z_lfsr_rst", {15'h0000, lfsr_rst}, 16'h0001);
        chk("z_lfsr_seed", {1'b0, lfsr_seed}, {1'b0, zero_exp});
        chk("z_gnt", {12'h000, gnt}, 16'h0000);
        cyc();
        chk("z_gnt2", {12'h000, gnt}, 16'h0000);
        cyc();
        chk("z_gnt3", {12'h000, gnt}, 16'h0008);
        req = 4'b0000;
        repeat (3) cyc();

        // Two pulses during one transaction: the newest seed wins.
        req = 4'b0001;
        cyc();
        reseed_req = 1'b1; seed_in = 15'h1111;
        cyc();
        seed_in = 15'h2222;
        cyc();
        reseed_req = 1'b0; req = 4'b0000;
        cyc();
        cyc();
        chk("nw_lfsr_seed", {1'b0, lfsr_seed}, 16'h2222);
        chk("nw_lfsr_rst", {15'h0000, lfsr_rst}, 16'h0001);
        repeat (2) cyc();

        // Reset during LOAD abandons the transaction.
        req = 4'b0001;
        cyc();
        chk("ab_gnt", {12'h000, gnt}, 16'h0001);
        cyc();
        rst = 1'b1;
        cyc();
        chk("ab_gnt_clr", {12'h000, gnt}, 16'h0000);
        chk("ab_valid", {15'h0000, rand_valid}, 16'h0000);
        rst = 1'b0; req = 4'b0000;
        cyc();
        chk("ab_seed_rst", {15'h0000, lfsr_rst}, 16'h0001);
        chk("ab_seed_val", {1'b0, lfsr_seed}, 16'h4A5D);
        chk("ab_valid2", {15'h0000, rand_valid}, 16'h0000);
        cyc();
        chk("ab_valid3", {15'h0000, rand_valid}, 16'h0000);
        chk("ab_data", {8'h00, rand_data}, 16'h0000);
        repeat (3) cyc();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
